// File: rtl/reg_file_if.sv
// Register-file bus: one write port, two read ports, issue/scoreboard signals.
interface reg_file_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 16
);
  logic              we;
  logic [3:0]        waddr;
  logic [WIDTH-1:0]  wdata;
  logic [3:0]        raddr_a;
  logic [3:0]        raddr_b;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;
  logic              rdy_a;
  logic              rdy_b;
  logic              issue_en;
  logic [3:0]        issue_addr;
  logic [NREG-1:0]   pending;

  // Requester side: drives writes, read addresses and issues.
  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, issue_en, issue_addr,
    input  rdata_a, rdata_b, rdy_a, rdy_b, pending
  );

  // Register-file side.
  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, issue_en, issue_addr,
    output rdata_a, rdata_b, rdy_a, rdy_b, pending
  );
endinterface

// File: rtl/reg_file.sv
// Two-read / one-write register file with write-through bypass and a
// one-bit-per-register pending scoreboard for operand readiness.
// Addresses are 4 bits wide; NREG may be at most 16.
module reg_file #(
  parameter int WIDTH = 16,
  parameter int NREG  = 16
) (
  input  logic        clk,
  input  logic        reset,
  reg_file_if.slave   bus
);

  logic [WIDTH-1:0] r_regs [NREG];
  logic [NREG-1:0]  r_pending;
  logic [NREG-1:0]  w_pending_nxt;
  logic [WIDTH-1:0] w_rdata_a;
  logic [WIDTH-1:0] w_rdata_b;
  logic             w_rdy_a;
  logic             w_rdy_b;
  logic             w_wr_ok;
  logic             w_iss_ok;

  // Addresses at or beyond NREG do not map to storage.
  function automatic logic f_in_range(input logic [3:0] addr);
    return (int'(addr) < NREG);
  endfunction

  assign w_wr_ok  = bus.we & f_in_range(bus.waddr);
  assign w_iss_ok = bus.issue_en & f_in_range(bus.issue_addr);

  // Data storage: reset clears everything, otherwise one write per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= {WIDTH{1'b0}};
      end
    end else if (w_wr_ok) begin
      r_regs[bus.waddr] <= bus.wdata;
    end
  end

  // Scoreboard next state: a write clears, an issue sets, and set is
  // applied last so it wins a same-address collision.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wr_ok) begin
      w_pending_nxt[bus.waddr] = 1'b0;
    end else begin
      w_pending_nxt = w_pending_nxt;
    end
    if (w_iss_ok) begin
      w_pending_nxt[bus.issue_addr] = 1'b1;
    end else begin
      w_pending_nxt = w_pending_nxt;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= {NREG{1'b0}};
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Read port A: bypass the in-flight write, else storage; forced idle in reset.
  always_comb begin
    w_rdata_a = {WIDTH{1'b0}};
    w_rdy_a   = 1'b1;
    if (reset || !f_in_range(bus.raddr_a)) begin
      w_rdata_a = {WIDTH{1'b0}};
      w_rdy_a   = 1'b1;
    end else if (w_wr_ok && (bus.waddr == bus.raddr_a)) begin
      w_rdata_a = bus.wdata;
      w_rdy_a   = 1'b1;
    end else begin
      w_rdata_a = r_regs[bus.raddr_a];
      w_rdy_a   = ~r_pending[bus.raddr_a];
    end
  end

  // Read port B: same structure as port A, fully independent.
  always_comb begin
    w_rdata_b = {WIDTH{1'b0}};
    w_rdy_b   = 1'b1;
    if (reset || !f_in_range(bus.raddr_b)) begin
      w_rdata_b = {WIDTH{1'b0}};
      w_rdy_b   = 1'b1;
    end else if (w_wr_ok && (bus.waddr == bus.raddr_b)) begin
      w_rdata_b = bus.wdata;
      w_rdy_b   = 1'b1;
    end else begin
      w_rdata_b = r_regs[bus.raddr_b];
      w_rdy_b   = ~r_pending[bus.raddr_b];
    end
  end

  assign bus.rdata_a = w_rdata_a;
  assign bus.rdata_b = w_rdata_b;
  assign bus.rdy_a   = w_rdy_a;
  assign bus.rdy_b   = w_rdy_b;
  assign bus.pending = r_pending;

endmodule
